// File: rtl/touch_gesture_ctrl_if.sv
// ---------------------------------------------------------------------------
// touch_gesture_ctrl_if
// Purpose : bundles the touch-controller report inputs and the zoom / page
//           outputs of touch_gesture_ctrl into one interface.
// Modports: slave  - used by touch_gesture_ctrl (reads i*, drives o*)
//           master - used by the environment (drives i*, reads o*)
// Signals : iREADY        report-valid level from the touch controller
//           iREG_X1/X2    touch X coordinates (10 b)
//           iREG_Y1/Y2    touch Y coordinates (9 b)
//           iREG_GESTURE  gesture code (8 b)
//           oX*_START/END, oY*_START/END  latched zoom coordinates
//           oZOOM_OUT     zoom direction
//           oZOOM_VALID   one-cycle pulse when a zoom gesture completes
//           oFACTOR_RSTN  active-low one-cycle pulse on a page change
//           oPAGE         current page index
//           oRD_ADDR      base read address of the current page
// ---------------------------------------------------------------------------
interface touch_gesture_ctrl_if #(
  parameter int ADDR_W = 23
);
  logic              iREADY;
  logic [9:0]        iREG_X1;
  logic [9:0]        iREG_X2;
  logic [8:0]        iREG_Y1;
  logic [8:0]        iREG_Y2;
  logic [7:0]        iREG_GESTURE;
  logic [9:0]        oX1_START;
  logic [9:0]        oX2_START;
  logic [9:0]        oX1_END;
  logic [9:0]        oX2_END;
  logic [8:0]        oY1_START;
  logic [8:0]        oY2_START;
  logic [8:0]        oY1_END;
  logic [8:0]        oY2_END;
  logic              oZOOM_OUT;
  logic              oZOOM_VALID;
  logic              oFACTOR_RSTN;
  logic [3:0]        oPAGE;
  logic [ADDR_W-1:0] oRD_ADDR;

  modport slave (
    input  iREADY, iREG_X1, iREG_X2, iREG_Y1, iREG_Y2, iREG_GESTURE,
    output oX1_START, oX2_START, oX1_END, oX2_END,
           oY1_START, oY2_START, oY1_END, oY2_END,
           oZOOM_OUT, oZOOM_VALID, oFACTOR_RSTN, oPAGE, oRD_ADDR
  );

  modport master (
    output iREADY, iREG_X1, iREG_X2, iREG_Y1, iREG_Y2, iREG_GESTURE,
    input  oX1_START, oX2_START, oX1_END, oX2_END,
           oY1_START, oY2_START, oY1_END, oY2_END,
           oZOOM_OUT, oZOOM_VALID, oFACTOR_RSTN, oPAGE, oRD_ADDR
  );
endinterface

// File: rtl/touch_gesture_ctrl.sv
// ---------------------------------------------------------------------------
// touch_gesture_ctrl
// Purpose : decodes touch-controller reports into frame-buffer page steps
//           (next / previous gestures) and two-point zoom rectangles.
// Ports   : iCLK   clock
//           iRSTN  asynchronous active-low reset
//           bus    touch_gesture_ctrl_if.slave (touch inputs, zoom and page
//                  outputs; see the interface file)
// Config  : define TOUCH_PAGE_WRAP_EN to make page stepping wrap around at
//           both ends; by default the page saturates at 0 and PAGE_NUM-1.
// ---------------------------------------------------------------------------
module touch_gesture_ctrl #(
  parameter int          PAGE_NUM    = 3,
  parameter int          RESET_PAGE  = 1,
  parameter logic [20:0] BUFFER_SIZE = 21'h12C000,
  parameter int          ADDR_W      = 23,
  parameter int          TMO_W       = 9,
  parameter logic [7:0]  NEXT_CODE   = 8'h1C,
  parameter logic [7:0]  PREV_CODE   = 8'h14
) (
  input  logic                 iCLK,
  input  logic                 iRSTN,
  touch_gesture_ctrl_if.slave  bus
);

  localparam logic [0:0]        ST_IDLE    = 1'b0;
  localparam logic [0:0]        ST_TOUCH   = 1'b1;
  localparam logic [3:0]        LAST_PAGE  = 4'(PAGE_NUM - 1);
  localparam logic [3:0]        RESET_PG   = 4'(RESET_PAGE);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BUFFER_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'((PAGE_NUM - 1) * BUFFER_SIZE);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PAGE * BUFFER_SIZE);

  logic [2:0]        r_sync;
  logic [0:0]        r_state;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_next;
  logic              r_prev;
  logic              r_zoom;
  logic              r_zoom_out;
  logic              r_zoom_valid;
  logic              r_factor_rstn;
  logic [3:0]        r_page;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [9:0]        r_x1_start, r_x2_start, r_x1_end, r_x2_end;
  logic [8:0]        r_y1_start, r_y2_start, r_y1_end, r_y2_end;

  logic              w_rise;
  logic              w_fall;
  logic              w_in_touch;
  logic              w_timeout;
  logic              w_zoom_gest;
  logic              w_zoom_end;
  logic              w_exit;
  logic              w_take_rise;
  logic              w_zoom_eff;
  logic [3:0]        w_page_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_page_chg;

  // Stage 0 is the metastability flop; edges are detected on stages 1/2.
  assign w_rise      = r_sync[1] & ~r_sync[2];
  assign w_fall      = r_sync[2] & ~r_sync[1];
  assign w_in_touch  = (r_state == ST_TOUCH);
  assign w_timeout   = r_tmo_cnt[TMO_W-1];
  assign w_zoom_gest = (bus.iREG_GESTURE[6:3] == 4'b1001);
  assign w_zoom_end  = bus.iREADY & (bus.iREG_GESTURE == 8'h00) & r_zoom;
  assign w_exit      = w_in_touch & (w_timeout | w_zoom_end);
  // A rise landing in the exit cycle is dropped; the FSM returns to IDLE.
  assign w_take_rise = w_rise & ~w_exit;
  // Flags read as clear in IDLE, so the rise that opens a gesture starts fresh.
  assign w_zoom_eff  = w_in_touch & r_zoom;

  // Next page / address selection at gesture exit (zoom wins, then prev, then next).
  always_comb begin
    w_page_nxt = r_page;
    w_addr_nxt = r_rd_addr;
    w_page_chg = 1'b0;
    if (w_exit && !r_zoom && r_prev) begin
      if (r_page == 4'd0) begin
`ifdef TOUCH_PAGE_WRAP_EN
        w_page_nxt = LAST_PAGE;
        w_addr_nxt = LAST_ADDR;
        w_page_chg = 1'b1;
`else
        w_page_chg = 1'b0;
`endif
      end else begin
        w_page_nxt = r_page - 4'd1;
        w_addr_nxt = r_rd_addr - STRIDE;
        w_page_chg = 1'b1;
      end
    end else if (w_exit && !r_zoom && r_next) begin
      if (r_page == LAST_PAGE) begin
`ifdef TOUCH_PAGE_WRAP_EN
        w_page_nxt = 4'd0;
        w_addr_nxt = {ADDR_W{1'b0}};
        w_page_chg = 1'b1;
`else
        w_page_chg = 1'b0;
`endif
      end else begin
        w_page_nxt = r_page + 4'd1;
        w_addr_nxt = r_rd_addr + STRIDE;
        w_page_chg = 1'b1;
      end
    end else begin
      w_page_chg = 1'b0;
    end
  end

  // Synchronizer for the report-valid level.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], bus.iREADY};
    end
  end

  // Gesture FSM and timeout counter; a fall coinciding with timeout still exits.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_state   <= ST_IDLE;
      r_tmo_cnt <= {TMO_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tmo_cnt <= {TMO_W{1'b0}};
          if (w_rise) begin
            r_state <= ST_TOUCH;
          end
        end
        ST_TOUCH: begin
          if (w_exit) begin
            r_state   <= ST_IDLE;
            r_tmo_cnt <= {TMO_W{1'b0}};
          end else if (w_fall) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
          end else begin
            r_tmo_cnt <= r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_tmo_cnt <= {TMO_W{1'b0}};
        end
      endcase
    end
  end

  // Gesture flags and coordinate capture on each accepted rise.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_next     <= 1'b0;
      r_prev     <= 1'b0;
      r_zoom     <= 1'b0;
      r_zoom_out <= 1'b0;
      r_x1_start <= 10'd0;
      r_x2_start <= 10'd0;
      r_y1_start <= 9'd0;
      r_y2_start <= 9'd0;
      r_x1_end   <= 10'd0;
      r_x2_end   <= 10'd0;
      r_y1_end   <= 9'd0;
      r_y2_end   <= 9'd0;
    end else if (w_take_rise) begin
      if (w_zoom_eff) begin
        r_next <= 1'b0;
        r_prev <= 1'b0;
        if (w_zoom_gest) begin
          r_x1_end <= bus.iREG_X1;
          r_x2_end <= bus.iREG_X2;
          r_y1_end <= bus.iREG_Y1;
          r_y2_end <= bus.iREG_Y2;
        end
      end else begin
        r_x1_start <= bus.iREG_X1;
        r_x2_start <= bus.iREG_X2;
        r_y1_start <= bus.iREG_Y1;
        r_y2_start <= bus.iREG_Y2;
        r_next     <= (w_in_touch & r_next) | (bus.iREG_GESTURE == NEXT_CODE);
        r_prev     <= (w_in_touch & r_prev) | (bus.iREG_GESTURE == PREV_CODE);
      end
      if (w_zoom_gest) begin
        r_zoom     <= 1'b1;
        r_zoom_out <= bus.iREG_GESTURE[0];
      end else begin
        r_zoom     <= w_zoom_eff;
        r_zoom_out <= w_in_touch & r_zoom_out;
      end
    end else if (!w_in_touch) begin
      r_next     <= 1'b0;
      r_prev     <= 1'b0;
      r_zoom     <= 1'b0;
      r_zoom_out <= 1'b0;
    end
  end

  // Page, address and the exit pulses; factor reset is low while the new page first shows.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_page        <= RESET_PG;
      r_rd_addr     <= RESET_ADDR;
      r_factor_rstn <= 1'b1;
      r_zoom_valid  <= 1'b0;
    end else begin
      r_page        <= w_page_nxt;
      r_rd_addr     <= w_addr_nxt;
      r_factor_rstn <= ~w_page_chg;
      r_zoom_valid  <= w_exit & r_zoom;
    end
  end

  assign bus.oX1_START    = r_x1_start;
  assign bus.oX2_START    = r_x2_start;
  assign bus.oY1_START    = r_y1_start;
  assign bus.oY2_START    = r_y2_start;
  assign bus.oX1_END      = r_x1_end;
  assign bus.oX2_END      = r_x2_end;
  assign bus.oY1_END      = r_y1_end;
  assign bus.oY2_END      = r_y2_end;
  assign bus.oZOOM_OUT    = r_zoom_out;
  assign bus.oZOOM_VALID  = r_zoom_valid;
  assign bus.oFACTOR_RSTN = r_factor_rstn;
  assign bus.oPAGE        = r_page;
  assign bus.oRD_ADDR     = r_rd_addr;

endmodule

// File: doc/touch_gesture_ctrl.md
TOUCH_GESTURE_CTRL -- requirements
Module: touch_gesture_ctrl

Interface
REQ-001 SHALL provide parameter PAGE_NUM, default 3: number of frame-buffer pages, 2..16.
REQ-002 SHALL provide parameter RESET_PAGE, default 1: page selected after reset, less than PAGE_NUM.
REQ-003 SHALL provide parameter BUFFER_SIZE, default 21'h12C000: page stride in address units.
REQ-004 SHALL provide parameter ADDR_W, default 23: read-address width.
REQ-005 SHALL provide parameter TMO_W, default 9: timeout counter width; timeout asserts when bit TMO_W-1 sets.
REQ-006 SHALL provide parameters NEXT_CODE 8'h1C and PREV_CODE 8'h14: gesture codes for page next and page previous.
REQ-007 SHALL have port iCLK, input, 1 bit: the single clock.
REQ-008 SHALL have port iRSTN, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port iREADY, input, 1 bit: touch-report-valid level from the touch controller.
REQ-010 SHALL have ports iREG_X1/iREG_X2 (input, 10 bits) and iREG_Y1/iREG_Y2 (input, 9 bits): touch coordinates.
REQ-011 SHALL have port iREG_GESTURE, input, 8 bits: gesture code.
REQ-012 SHALL have ports oX1_START/oX2_START/oX1_END/oX2_END (output, 10 bits) and oY1_START/oY2_START/oY1_END/oY2_END (output, 9 bits): latched zoom coordinates.
REQ-013 SHALL have port oZOOM_OUT, output, 1 bit: zoom direction (iREG_GESTURE[0]).
REQ-014 SHALL have port oZOOM_VALID, output, 1 bit: one-cycle pulse when a zoom gesture completes.
REQ-015 SHALL have port oFACTOR_RSTN, output, 1 bit: active-low one-cycle reset pulse to the scale block on a page change.
REQ-016 SHALL have port oPAGE, output, 4 bits: current page index.
REQ-017 SHALL have port oRD_ADDR, output, ADDR_W bits: registered base address of the current page.

Function
REQ-018 SHALL pass iREADY through a 3-stage shift register; rise = stage1 & !stage2, fall = stage2 & !stage1.
REQ-019 SHALL implement FSM IDLE->TOUCH on rise; in IDLE, clear the next, prev and zoom flags and oZOOM_OUT.
REQ-020 SHALL, in TOUCH, clear the timeout counter on fall and otherwise increment it; leave TOUCH for IDLE on timeout, or on zoom_end (iREADY & iREG_GESTURE==0 & zoom flag).
REQ-021 SHALL, on each rise in TOUCH while the zoom flag is clear, latch the coordinates into the *_START registers and set the next/prev flag if the gesture equals NEXT_CODE/PREV_CODE.
REQ-022 SHALL, on each rise in TOUCH while the zoom flag is set, clear next/prev and latch the coordinates into the *_END registers only when iREG_GESTURE[6:3]==4'b1001.
REQ-023 SHALL, on a rise with iREG_GESTURE[6:3]==4'b1001, set the zoom flag and set oZOOM_OUT from iREG_GESTURE[0].
REQ-024 SHALL define exit = TOUCH & (timeout | zoom_end); on exit, pulse oZOOM_VALID if zoom is set, step the page down if prev is set, or step it up if next is set.
REQ-025 SHALL track oRD_ADDR incrementally (±BUFFER_SIZE, no multiplier) and update it in the same cycle as oPAGE; oRD_ADDR == oPAGE*BUFFER_SIZE at all times.
REQ-026 SHALL drive oFACTOR_RSTN low for exactly the cycle after any page change and high otherwise; a blocked step (boundary, non-wrap) SHALL NOT pulse it.
REQ-027 SHALL treat a simultaneous fall and timeout as timeout: the FSM exits and the counter clears.
REQ-028 SHALL, on a rise arriving in the exit cycle, return to IDLE first; the rise is then lost.

Reset
REQ-029 SHALL, on iRSTN low, put the FSM in IDLE, clear all flags, the counter and the sync stages, and zero all coordinate outputs.
REQ-030 SHALL, on iRSTN low, set oPAGE=RESET_PAGE, oRD_ADDR=RESET_PAGE*BUFFER_SIZE, oFACTOR_RSTN=1, oZOOM_VALID=0 and oZOOM_OUT=0.
REQ-031 SHALL abort any in-progress gesture without a page step or pulse when reset asserts mid-gesture.

Configuration
REQ-032 SHALL, with TOUCH_PAGE_WRAP_EN defined, wrap next at page PAGE_NUM-1 to page 0 (address 0) and prev at page 0 to PAGE_NUM-1 (address (PAGE_NUM-1)*BUFFER_SIZE).
REQ-033 SHALL, without TOUCH_PAGE_WRAP_EN, saturate the page at 0 and at PAGE_NUM-1.

Verification
REQ-034 SHALL verify: reset, then NEXT_CODE rise and 256 idle cycles -> oPAGE 1->2, oRD_ADDR 0x258000, one-cycle oFACTOR_RSTN low.
REQ-035 SHALL verify: at page 2, NEXT_CODE with wrap off -> page stays 2, no pulse; with wrap on -> page 0, oRD_ADDR 0.
REQ-036 SHALL verify: rise with 8'h49 at (100,50,300,200), rise with 8'h49 at (50,40,350,210), then iREADY=1 with gesture 0 -> START/END registers hold those values, oZOOM_OUT=1, oZOOM_VALID one pulse, page unchanged.
REQ-037 SHALL verify: PREV_CODE at page 0, wrap off -> no change; wrap on -> page PAGE_NUM-1, address (PAGE_NUM-1)*BUFFER_SIZE.
REQ-038 SHALL verify: iRSTN low 100 cycles into a NEXT gesture -> no step, oPAGE=RESET_PAGE, FSM IDLE.
REQ-039 SHALL verify: fall at cycle 200 of TOUCH -> counter restarts, exit at least 256 cycles later.
